// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 4-digit multiplexed 7-segment scan path.
// Segment patterns are active-low (common-anode), dp in bit 7.
// Digit enables are active-low one-hot.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low glyphs for decimal digits, the error marker and an unlit digit
  localparam logic [7:0] GLYPH_0     = 8'hC0;
  localparam logic [7:0] GLYPH_1     = 8'hF9;
  localparam logic [7:0] GLYPH_2     = 8'hA4;
  localparam logic [7:0] GLYPH_3     = 8'hB0;
  localparam logic [7:0] GLYPH_4     = 8'h99;
  localparam logic [7:0] GLYPH_5     = 8'h92;
  localparam logic [7:0] GLYPH_6     = 8'h82;
  localparam logic [7:0] GLYPH_7     = 8'hF8;
  localparam logic [7:0] GLYPH_8     = 8'h80;
  localparam logic [7:0] GLYPH_9     = 8'h90;
  localparam logic [7:0] GLYPH_ERR   = 8'hFD;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  // Active-low one-hot digit enables; EN_NONE switches every digit off
  localparam logic [3:0] EN_DIGIT0 = 4'b1110;
  localparam logic [3:0] EN_DIGIT1 = 4'b1101;
  localparam logic [3:0] EN_DIGIT2 = 4'b1011;
  localparam logic [3:0] EN_DIGIT3 = 4'b0111;
  localparam logic [3:0] EN_NONE   = 4'b1111;

  // Blink phase: ON shows glyphs normally, OFF hides masked digits
  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_e;

  // Translate the 2-bit digit pointer into its active-low enable pattern
  function automatic logic [3:0] digitEnable(input logic [1:0] ptr);
    logic [3:0] en;
    case (ptr)
      2'd0:    en = EN_DIGIT0;
      2'd1:    en = EN_DIGIT1;
      2'd2:    en = EN_DIGIT2;
      default: en = EN_DIGIT3;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// seg7_glyph_dec: combinational nibble-to-segment decoder.
// Blank forces an unlit digit; nibbles above 9 show the error glyph.
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [7:0] pattern_o
);

  // Blank wins over any glyph, otherwise look the nibble up
  always_comb begin
    pattern_o = GLYPH_ERR;
    if (blank_i) begin
      pattern_o = GLYPH_BLANK;
    end else begin
      case (nibble_i)
        4'd0:    pattern_o = GLYPH_0;
        4'd1:    pattern_o = GLYPH_1;
        4'd2:    pattern_o = GLYPH_2;
        4'd3:    pattern_o = GLYPH_3;
        4'd4:    pattern_o = GLYPH_4;
        4'd5:    pattern_o = GLYPH_5;
        4'd6:    pattern_o = GLYPH_6;
        4'd7:    pattern_o = GLYPH_7;
        4'd8:    pattern_o = GLYPH_8;
        4'd9:    pattern_o = GLYPH_9;
        default: pattern_o = GLYPH_ERR;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_sched.sv
// seg7_scan_sched: frame-synchronous scan scheduler for a 4-digit
// common-anode 7-segment display. New BCD values are double-buffered and
// only promoted at frame boundaries, so a frame never mixes old and new
// digits. Optional blink support is compiled in with SEG7_BLINK_EN.
module seg7_scan_sched
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 1024
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic        scan_clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank_en,
`ifdef SEG7_BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  output logic [3:0]  Enable_7Seg,
  output logic [7:0]  display_7Seg,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] prescale_q, prescale_d;
  logic [1:0]       digitPtr_q, digitPtr_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pending_q, pending_d;
  logic             pendFlag_q, pendFlag_d;
  logic             frameDone_q;
  logic [3:0]       enable_q, enable_d;
  logic [7:0]       segment_q, segment_d;

  logic             tick;
  logic             frameBoundary;
  logic             loadFire;
  logic [3:0]       curNibble;
  logic             lzBlank;
  logic             blinkHide;
  logic [7:0]       glyph;

  assign tick          = (prescale_q == CNT_MAX);
  assign frameBoundary = tick && (digitPtr_q == 2'd3);
  assign load_ready    = ~pendFlag_q;
  assign loadFire      = load_valid && ~pendFlag_q;

  // Scan timebase: prescaler wraps every SCAN_DIV cycles and steps the digit pointer
  always_comb begin
    prescale_d = tick ? '0 : prescale_q + CNT_W'(1);
    digitPtr_d = tick ? digitPtr_q + 2'd1 : digitPtr_q;
  end

  // Double buffer: a held value is promoted at the boundary; a capture in that same cycle waits a frame
  always_comb begin
    active_d   = active_q;
    pending_d  = pending_q;
    pendFlag_d = pendFlag_q;
    if (frameBoundary && pendFlag_q) begin
      active_d   = pending_q;
      pendFlag_d = 1'b0;
    end else if (loadFire) begin
      pending_d  = bcd_in;
      pendFlag_d = 1'b1;
    end
  end

  // Pick the current digit and decide leading-zero blanking from the more significant digits
  always_comb begin
    curNibble = active_q[{digitPtr_q, 2'b00} +: 4];
    lzBlank   = 1'b0;
    if (blank_en) begin
      case (digitPtr_q)
        2'd3:    lzBlank = (active_q[15:12] == 4'd0);
        2'd2:    lzBlank = (active_q[15:8] == 8'd0);
        2'd1:    lzBlank = (active_q[15:4] == 12'd0);
        default: lzBlank = 1'b0;
      endcase
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] blinkCnt_q, blinkCnt_d;
  blink_phase_e     blinkPhase_q, blinkPhase_d;

  // Count frame boundaries and flip the blink phase every BLINK_FRAMES of them
  always_comb begin
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (frameBoundary) begin
      if (blinkCnt_q == BLK_MAX) begin
        blinkCnt_d   = '0;
        blinkPhase_d = (blinkPhase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        blinkCnt_d = blinkCnt_q + BLK_W'(1);
      end
    end
  end

  // Blink state register; phase starts visible after reset
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= BLINK_ON;
    end else begin
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  assign blinkHide = (blinkPhase_q == BLINK_OFF) && blink_mask[digitPtr_q];
`else
  assign blinkHide = 1'b0;
`endif

  seg7_glyph_dec u_glyph (
    .nibble_i  (curNibble),
    .blank_i   (lzBlank | blinkHide),
    .pattern_o (glyph)
  );

  // Display pins are registered, so they trail the pointer and active value by one cycle
  always_comb begin
    enable_d  = digitEnable(digitPtr_q);
    segment_d = glyph;
  end

  // Core state register; reset drops any in-flight value and restarts at digit 0
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q  <= '0;
      digitPtr_q  <= 2'd0;
      active_q    <= 16'h0000;
      pending_q   <= 16'h0000;
      pendFlag_q  <= 1'b0;
      frameDone_q <= 1'b0;
      enable_q    <= EN_NONE;
      segment_q   <= GLYPH_BLANK;
    end else begin
      prescale_q  <= prescale_d;
      digitPtr_q  <= digitPtr_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pendFlag_q  <= pendFlag_d;
      frameDone_q <= frameBoundary;
      enable_q    <= enable_d;
      segment_q   <= segment_d;
    end
  end

  assign Enable_7Seg  = enable_q;
  assign display_7Seg = segment_q;
  assign frame_done   = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_sched.sv
// tb_seg7_scan_sched: scoreboard bench for seg7_scan_sched with SCAN_DIV=4.
// Expected frames are queued by frame number; a monitor captures each
// displayed frame and compares it against the queue head.
// Define SEG7_BLINK_EN to also exercise the blink path (BLINK_FRAMES=2).
`timescale 1ns/1ps
module tb_seg7_scan_sched;

  localparam int SCAN_DIV = 4;
  localparam int SAMPLES  = 4 * SCAN_DIV;
  localparam logic [3:0][3:0] EXP_EN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic        scan_clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        load_valid;
  logic        load_ready;
  logic        blank_en;
  logic [3:0]  Enable_7Seg;
  logic [7:0]  display_7Seg;
  logic        frame_done;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  typedef struct {
    int              frame;
    string           name;
    logic [3:0][7:0] seg;
  } expFrame_t;

  expFrame_t expQ[$];
  int nChecks = 0;
  int nFail   = 0;
  int frameCnt;

  logic [3:0]         capEn  [SAMPLES];
  logic [7:0]         capSeg [SAMPLES];
  logic [SAMPLES-1:0] capDone;

  seg7_scan_sched #(
    .SCAN_DIV(SCAN_DIV)
`ifdef SEG7_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .scan_clk     (scan_clk),
    .rst_n        (rst_n),
    .bcd_in       (bcd_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .blank_en     (blank_en),
`ifdef SEG7_BLINK_EN
    .blink_mask   (blink_mask),
`endif
    .Enable_7Seg  (Enable_7Seg),
    .display_7Seg (display_7Seg),
    .frame_done   (frame_done)
  );

  always #5 scan_clk = ~scan_clk;

  // Frame n is the one displayed after the n-th frame_done pulse since reset
  always @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) frameCnt <= 0;
    else if (frame_done) frameCnt <= frameCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int frame, input string name,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
    expFrame_t e;
    e.frame = frame;
    e.name  = name;
    e.seg   = {d3, d2, d1, d0};
    expQ.push_back(e);
  endtask

  task automatic scoreFrame(input int f);
    expFrame_t e;
    int        bad;
    while (expQ.size() > 0 && expQ[0].frame < f) begin
      e = expQ.pop_front();
      nChecks++;
      nFail++;
      $display("[TB] FAIL %s: frame %0d never observed, now at frame %0d", e.name, e.frame, f);
    end
    if (expQ.size() > 0 && expQ[0].frame == f) begin
      e = expQ.pop_front();
      for (int d = 0; d < 4; d++) begin
        bad = -1;
        for (int s = d * SCAN_DIV; s < (d + 1) * SCAN_DIV; s++) begin
          if (bad < 0 && (capEn[s] !== EXP_EN[d] || capSeg[s] !== e.seg[d])) bad = s;
        end
        nChecks++;
        if (bad >= 0) begin
          nFail++;
          $display("[TB] FAIL %s digit %0d: sample %0d got en=%b seg=%h, expected en=%b seg=%h",
                   e.name, d, bad, capEn[bad], capSeg[bad], EXP_EN[d], e.seg[d]);
        end
      end
      checkOutput({e.name, "_frame_done"}, 16'(capDone), 16'h8000);
    end
  endtask

  // Monitor: capture the 16 displayed cycles of each frame and score them
  initial begin : monitor
    int curFrame;
    int idx;
    curFrame = 0;
    idx      = 0;
    forever begin
      @(negedge scan_clk);
      if (!rst_n) begin
        curFrame = 0;
        idx      = 0;
      end else if (frameCnt > 0) begin
        if (frameCnt != curFrame) begin
          curFrame = frameCnt;
          idx      = 0;
        end
        if (idx < SAMPLES) begin
          capEn[idx]   = Enable_7Seg;
          capSeg[idx]  = display_7Seg;
          capDone[idx] = frame_done;
          idx++;
          if (idx == SAMPLES) scoreFrame(curFrame);
        end
      end
    end
  end

  task automatic waitNeg(input int n);
    repeat (n) @(negedge scan_clk);
  endtask

  // Returns on the negedge of the frame_done cycle, with the number of the frame now starting
  task automatic syncFrame(output int nextFrame);
    int n;
    n = 0;
    do begin
      @(negedge scan_clk);
      n++;
    end while (!frame_done && n < 4 * SAMPLES);
    if (!frame_done) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL frame_sync: no frame_done within %0d cycles", n);
    end
    nextFrame = frameCnt + 1;
  endtask

  task automatic applyStimulus(input logic [15:0] value);
    int n;
    n          = 0;
    bcd_in     = value;
    load_valid = 1'b1;
    while (!load_ready && n < 4 * SAMPLES) begin
      @(negedge scan_clk);
      n++;
    end
    if (!load_ready) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL handshake: load_ready stayed low for %0d cycles", n);
    end
    @(negedge scan_clk);
    load_valid = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks, %0d failures", nChecks, nFail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int f;
    int n;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    bcd_in     = 16'h0000;
    blank_en   = 1'b0;
`ifdef SEG7_BLINK_EN
    blink_mask = 4'b0000;
`endif
    waitNeg(3);
    checkOutput("reset_enable", 16'(Enable_7Seg), 16'h000F);
    checkOutput("reset_segments", 16'(display_7Seg), 16'h00FF);
    checkOutput("reset_frame_done", 16'(frame_done), 16'h0000);
    checkOutput("reset_load_ready", 16'(load_ready), 16'h0001);

    rst_n = 1'b1;
    #1;
    checkOutput("first_cycle_enable", 16'(Enable_7Seg), 16'h000F);
    checkOutput("first_cycle_segments", 16'(display_7Seg), 16'h00FF);
    @(negedge scan_clk);
    checkOutput("second_cycle_enable", 16'(Enable_7Seg), 16'h000E);
    checkOutput("second_cycle_segments", 16'(display_7Seg), 16'h00C0);

    // Basic scan of 1234
    syncFrame(f);
    pushExp(f, "zero_frame", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    waitNeg(2);
    applyStimulus(16'h1234);
    pushExp(f + 1, "basic_1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Leading-zero blanking on and off
    syncFrame(f);
    blank_en = 1'b1;
    waitNeg(2);
    applyStimulus(16'h0007);
    pushExp(f + 1, "blank_on_0007", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    syncFrame(f);
    syncFrame(f);
    blank_en = 1'b0;
    pushExp(f, "blank_off_0007", 8'hF8, 8'hC0, 8'hC0, 8'hC0);

    // Load while pointer = 1; old value must finish its frame
    syncFrame(f);
    pushExp(f, "old_frame_kept", 8'hF8, 8'hC0, 8'hC0, 8'hC0);
    waitNeg(5);
    applyStimulus(16'h5678);
    checkOutput("ready_low_after_load", 16'(load_ready), 16'h0000);
    pushExp(f + 1, "new_frame_5678", 8'h80, 8'hF8, 8'h82, 8'h92);
    waitNeg(9);
    checkOutput("ready_low_in_boundary_cycle", 16'(load_ready), 16'h0000);
    waitNeg(1);
    checkOutput("ready_high_after_boundary", 16'(load_ready), 16'h0001);
    checkOutput("frame_done_after_boundary", 16'(frame_done), 16'h0001);

    // Load in the boundary cycle itself, with an error nibble under blanking
    syncFrame(f);
    blank_en = 1'b1;
    waitNeg(15);
    applyStimulus(16'h00A0);
    checkOutput("collision_ready_low", 16'(load_ready), 16'h0000);
    pushExp(f + 1, "collision_held_5678", 8'h80, 8'hF8, 8'h82, 8'h92);
    pushExp(f + 2, "error_glyph_00A0", 8'hC0, 8'hFD, 8'hFF, 8'hFF);

    // Reset at pointer = 2 with a value pending
    syncFrame(f);
    syncFrame(f);
    waitNeg(1);
    applyStimulus(16'h1111);
    waitNeg(7);
    checkOutput("pending_before_reset", 16'(load_ready), 16'h0000);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_enable", 16'(Enable_7Seg), 16'h000F);
    checkOutput("midreset_segments", 16'(display_7Seg), 16'h00FF);
    checkOutput("midreset_load_ready", 16'(load_ready), 16'h0001);
    checkOutput("midreset_frame_done", 16'(frame_done), 16'h0000);
`ifdef SEG7_BLINK_EN
    blink_mask = 4'b0001;
`endif
    waitNeg(2);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_first_enable", 16'(Enable_7Seg), 16'h000F);
    @(negedge scan_clk);
    checkOutput("post_reset_enable", 16'(Enable_7Seg), 16'h000E);
    checkOutput("post_reset_segments", 16'(display_7Seg), 16'h00C0);
    checkOutput("post_reset_load_ready", 16'(load_ready), 16'h0001);

    syncFrame(f);
    pushExp(f, "post_reset_blank", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    waitNeg(2);
    applyStimulus(16'h4321);
`ifdef SEG7_BLINK_EN
    pushExp(f + 1, "blink_off_a", 8'hFF, 8'hA4, 8'hB0, 8'h99);
    pushExp(f + 2, "blink_off_b", 8'hFF, 8'hA4, 8'hB0, 8'h99);
    pushExp(f + 3, "blink_on_a", 8'hF9, 8'hA4, 8'hB0, 8'h99);
    pushExp(f + 4, "blink_on_b", 8'hF9, 8'hA4, 8'hB0, 8'h99);
`else
    pushExp(f + 1, "post_reset_4321", 8'hF9, 8'hA4, 8'hB0, 8'h99);
`endif

    n = 0;
    while (expQ.size() > 0 && n < 8 * SAMPLES) begin
      @(negedge scan_clk);
      n++;
    end
    if (expQ.size() > 0) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL scoreboard_drain: %0d expected frames never observed", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_sched.md
# seg7_scan_sched

Scan scheduler for the 4-digit multiplexed common-anode 7-segment display. It accepts a 16-bit BCD value through a valid/ready handshake and applies it only at frame boundaries, so no frame ever shows a mix of old and new digits. It rotates the active-low digit enables at a programmable rate and performs leading-zero blanking. It sits between the BCD counter/datapath and the display pins, and replaces ad-hoc combinational scan logic.

## Interface
- SCAN_DIV, 1024: scan_clk cycles per digit slot; legal range ≥2.
- BLINK_FRAMES, 64: frames per blink half-period. Used only when SEG7_BLINK_EN is defined.

- scan_clk  in  1: the single clock; all state is on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- bcd_in  in  16: four BCD digits, [3:0] is the units digit and [15:12] the thousands digit.
- load_valid  in  1: bcd_in is presented.
- load_ready  out  1: scheduler can accept a value.
- blank_en  in  1: enables leading-zero blanking.
- blink_mask  in  4: per-digit blink enable. This port exists only with SEG7_BLINK_EN.
- Enable_7Seg  out  4: active-low one-hot digit enable. Digit 0 is 4'b1110.
- display_7Seg  out  8: active-low segment pattern, dp in bit 7.
- frame_done  out  1: one-cycle pulse at each frame boundary.

## Operation
- **Prescaler.** Counts 0..SCAN_DIV-1 and wraps. `tick` is asserted in the cycle where the count equals SCAN_DIV-1.
- **Digit pointer.** 2-bit pointer, advances on `tick`. It wraps 3→0.
- **Frame boundary.** A `tick` with pointer = 3. frame_done is registered and is high in the cycle after the boundary.
- **Two registers.** `active` (displayed) and `pending`, plus a `pend_flag` bit.
- **Handshake.**
  - load_ready = ~pend_flag.
  - Transfer occurs when load_valid && load_ready: bcd_in → pending and pend_flag is set.
  - load_valid without ready is ignored. The source holds it.
- **Boundary update.** At a frame boundary with pend_flag already set at the start of the cycle:
  - pending → active;
  - pend_flag is cleared, so load_ready returns high in the next cycle.
- **Simultaneous capture.** A transfer in the boundary cycle itself waits for the following boundary.
- **Leading-zero blanking** (blank_en = 1):
  - digit 3 is blank if zero;
  - digit 2 is blank if digits 3 and 2 are zero;
  - digit 1 is blank if digits 3..1 are zero;
  - digit 0 is never blanked.
  - A blanked digit keeps its enable asserted and drives 8'hFF.
- **Glyphs.**
  - 0..9 map to C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - A nibble >9 drives error glyph 8'hFD. A nonzero nibble counts as significant for blanking.
- **Outputs.** Enable_7Seg and display_7Seg are registered from the pointer and `active`.

## Timing
- **Reset values** (asynchronous, held during reset):
  - Enable_7Seg = 4'b1111, display_7Seg = 8'hFF, frame_done = 0, load_ready = 1;
  - prescaler = 0, pointer = 0, active = 0, pending = 0, pend_flag = 0.
- **First drive.** In the first cycle after reset release, outputs still show the reset values. From the second cycle they drive digit 0 of active = 0000, i.e. C0.
- **Latency to outputs.**
  - Pointer or active change → outputs: 1 cycle.
  - Accepted load → visible: applied at the next qualifying boundary, appearing on the outputs with digit 0 one cycle later.
- **Slot length.** Each digit slot is exactly SCAN_DIV cycles; a frame is 4·SCAN_DIV cycles.
- **Reset mid-frame.** Any in-flight pending value is discarded. Scanning restarts at digit 0.

## Configuration
- **SEG7_BLINK_EN defined:**
  - adds the blink_mask port and a frame counter that toggles blink phase every BLINK_FRAMES frame boundaries;
  - phase resets to "on";
  - in "off" phase, digits with blink_mask set drive 8'hFF, with enable unchanged;
  - blink overrides glyph and blanking.
- **Undefined:** no port, no counter, no blink logic.

## Structure
- Package `seg7_pkg` holds:
  - digit glyph constants (0–9, error 8'hFD, blank 8'hFF);
  - NUM_DIGITS = 4;
  - one-hot enable constants.
- Sub-module `seg7_glyph_dec`: 4-bit nibble plus blank flag in, 8-bit pattern out (combinational).
- The top holds the prescaler, pointer, handshake, blanking and, with SEG7_BLINK_EN, the blink logic.

## Test plan
- **Basic scan.** SCAN_DIV=4, load 16'h1234 → after the next boundary:
  - enables cycle 1110/1101/1011/0111, 4 cycles each;
  - segments 99, B0, A4, F9;
  - frame_done pulses every 16 cycles.
- **Blanking.** Load 16'h0007:
  - blank_en=1 → digits 3..1 show FF, digit 0 shows F8;
  - blank_en=0 → C0, C0, C0, F8.
- **Mid-frame load.** Load 16'h5678 while pointer=1:
  - load_ready goes low the next cycle;
  - the rest of the frame still shows the old value;
  - new digits appear from digit 0 of the next frame;
  - load_ready is high 1 cycle after the boundary.
- **Boundary collision and error glyph.**
  - Assert load_valid exactly on the boundary cycle → value is applied only at the following boundary.
  - 16'h00A0 → digit 1 shows FD, and it is not blanked.
- **Reset mid-operation.** Assert rst_n low at pointer=2 with pend_flag set → outputs are immediately 1111/FF, load_ready=1, and after release digit 0 shows C0.
- **Blink** (SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001) → digit 0 shows FF during alternating 2-frame windows and the other digits are unaffected.
